scpad_dram_req_gen: RTL and testbench
=====================================

Name: scpad_dram_req_gen

Overview:
- Upstream stage of the scratchpad backend DRAM request queue. Converts one scheduler transaction into the per-beat sub-request stream that the queue consumes.
- A transaction is a block of rows with a base address, a row stride and a valid byte count per row.
- Each row becomes up to 8 beat requests. Each beat carries the DRAM address, id, sub_id, num_request and byte mask.
- Obeys queue back-pressure (dram_queue_full, be_stall) and reports transaction start and finish.

Parameters:
- DRAM_ADDR_WIDTH, 32, DRAM byte address width
- DRAM_ID_WIDTH, 5, request id width
- BEAT_BYTES, 8, bytes per DRAM beat; also the mask width (DRAM_VECTOR_MASK)
- ROW_BYTES, 64, maximum bytes per scratchpad row (8 beats max)
- ROWS_WIDTH, 6, row-count width

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset
- txn_valid  in  1  scheduler transaction valid
- txn_ready  out  1  generator idle; transaction accepted when txn_valid&&txn_ready
- txn_write  in  1  1 = scpad store (DRAM write)
- txn_base_addr  in  DRAM_ADDR_WIDTH  first row byte address
- txn_row_stride  in  DRAM_ADDR_WIDTH  byte distance between rows
- txn_row_bytes  in  7  valid bytes per row, 0..ROW_BYTES
- txn_rows  in  ROWS_WIDTH  row count
- txn_id  in  DRAM_ID_WIDTH  id of row 0
- dram_queue_full  in  1  queue cannot accept
- be_stall  in  1  backend stall
- sched_valid  out  1  sub-request valid
- sched_write  out  1  latched txn_write
- dram_addr  out  DRAM_ADDR_WIDTH  beat address
- id  out  DRAM_ID_WIDTH  row id
- sub_id  out  3  beat index in row
- num_request  out  3  beats in row minus 1
- dram_vector_mask  out  BEAT_BYTES  byte enables
- initial_request_done  out  1  one-cycle pulse
- txn_done  out  1  one-cycle pulse

Behaviour:
- Reset values: all outputs 0 except txn_ready=1; FSM in IDLE. Reset wins over every other event, including mid-transaction; the partial transaction is dropped with no txn_done.
- FSM states:
  - IDLE: txn_ready=1. On accept, latch all txn_* fields; set row_cnt=0, beat_cnt=0, row_addr=base. If txn_rows==0 or txn_row_bytes==0, go to FIN; otherwise go to ISSUE.
  - ISSUE: sched_valid=1, outputs driven from registers only (no combinational path from inputs).
  - FIN: txn_done=1 for one cycle, then IDLE.
- Accept rule: a beat is accepted on a cycle with sched_valid && !dram_queue_full && !be_stall. While not accepted, every output is held stable.
- Per-row arithmetic:
  - beats = ceil(row_bytes/BEAT_BYTES), 1..8; num_request = beats-1.
  - dram_addr = row_addr + sub_id*BEAT_BYTES, wrapping modulo 2^DRAM_ADDR_WIDTH.
  - id = txn_id + row_cnt, wrapping modulo 2^DRAM_ID_WIDTH.
  - dram_vector_mask is all ones, except on the last beat when r = row_bytes mod BEAT_BYTES is nonzero; that beat gets the low r bits set.
- Advance on acceptance:
  - If sub_id < num_request: sub_id++.
  - Else: sub_id=0, row_cnt++, row_addr += stride.
  - If the last beat of the last row was accepted: sched_valid drops next cycle and the FSM goes to FIN.
- initial_request_done pulses the cycle after the first beat of a transaction is accepted. It may coincide with txn_done's FIN cycle only for single-beat transactions.
- A new transaction is accepted at earliest the cycle after FIN, giving 1 idle cycle between transactions.
- Throughput: 1 beat/cycle without stalls.

Decomposition:
- scpad_pkg gets:
  - BEAT_BYTES, ROW_BYTES
  - scpad_txn_t struct (write, base_addr, row_stride, row_bytes, rows, id)
  - req_gen_state_t enum {IDLE, ISSUE, FIN}
- Optional sub-module scpad_beat_mask_gen, a combinational mask/num_request calculator from row_bytes. Everything else stays in one module.

Test Plan:
- Write, base 0x1000, row_bytes 64, rows 1, id 3, no stalls:
  - 8 consecutive beats, dram_addr 0x1000..0x1038 step 8, sub_id 0..7, num_request 7, mask 0xFF, id 3, sched_write 1.
  - txn_done one cycle after the last beat.
- Read, row_bytes 20, rows 1:
  - 3 beats, masks 0xFF, 0xFF, 0x0F; num_request 2.
- rows 2, stride 0x100, base 0x2000, row_bytes 16, id 31:
  - Row 0: addrs 0x2000 and 0x2008, id 31.
  - Row 1: addrs 0x2100 and 0x2108, id 0 (id wrap).
- dram_queue_full held 3 cycles while sub_id=2 is presented, then be_stall 1 cycle:
  - addr, sub_id and mask held stable throughout the stall.
  - Total beat count unchanged.
- txn_rows=0 accepted:
  - No sched_valid.
  - txn_done pulses the cycle after accept; txn_ready returns the following cycle.
- nRST low during beat 4 of 8:
  - Next cycle all outputs 0, txn_ready=1, no txn_done.
  - A new transaction then starts from sub_id 0.

Source files
------------

// File: rtl/scpad_pkg.sv
// Shared types and sizes for the scratchpad DRAM
// request generator.
package scpad_pkg;

  localparam int DRAM_ADDR_WIDTH = 32;
  localparam int DRAM_ID_WIDTH   = 5;
  localparam int ROWS_WIDTH      = 6;
  localparam int BEAT_BYTES      = 8;
  localparam int ROW_BYTES       = 64;
  localparam int RB_WIDTH        = 7;
  localparam int SUB_WIDTH       = 3;

  typedef struct packed {
    logic                       write;
    logic [DRAM_ADDR_WIDTH-1:0] base_addr;
    logic [DRAM_ADDR_WIDTH-1:0] row_stride;
    logic [RB_WIDTH-1:0]        row_bytes;
    logic [ROWS_WIDTH-1:0]      rows;
    logic [DRAM_ID_WIDTH-1:0]   id;
  } scpad_txn_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FIN
  } req_gen_state_t;

endpackage

// File: rtl/scpad_beat_mask_gen.sv
// Beats-per-row and last-beat byte mask from a
// row's valid byte count.
module scpad_beat_mask_gen
  import scpad_pkg::*;
(
  input  logic [RB_WIDTH-1:0]   row_bytes_i,
  output logic [SUB_WIDTH-1:0]  num_req_o,
  output logic [BEAT_BYTES-1:0] last_mask_o
);

  logic [5:0] rb_m1;
  logic [2:0] rem;

  // 64 bytes has low bits 0; minus one still yields 63
  always_comb begin
    rb_m1       = row_bytes_i[5:0] - 6'd1;
    rem         = row_bytes_i[2:0];
    num_req_o   = (row_bytes_i == '0) ? '0 : rb_m1[5:3];
    last_mask_o = {BEAT_BYTES{1'b1}};
    if (rem != 3'd0)
      last_mask_o = ~({BEAT_BYTES{1'b1}} << rem);
  end

endmodule

// File: rtl/scpad_dram_req_gen.sv
// Turns one scheduler transaction into a stream of
// per-beat DRAM sub-requests for the backend queue.
module scpad_dram_req_gen
  import scpad_pkg::*;
(
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       txn_valid,
  output logic                       txn_ready,
  input  logic                       txn_write,
  input  logic [DRAM_ADDR_WIDTH-1:0] txn_base_addr,
  input  logic [DRAM_ADDR_WIDTH-1:0] txn_row_stride,
  input  logic [RB_WIDTH-1:0]        txn_row_bytes,
  input  logic [ROWS_WIDTH-1:0]      txn_rows,
  input  logic [DRAM_ID_WIDTH-1:0]   txn_id,
  input  logic                       dram_queue_full,
  input  logic                       be_stall,
  output logic                       sched_valid,
  output logic                       sched_write,
  output logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
  output logic [DRAM_ID_WIDTH-1:0]   id,
  output logic [SUB_WIDTH-1:0]       sub_id,
  output logic [SUB_WIDTH-1:0]       num_request,
  output logic [BEAT_BYTES-1:0]      dram_vector_mask,
  output logic                       initial_request_done,
  output logic                       txn_done
);

  scpad_txn_t txn_in;
  req_gen_state_t state_q;

  logic                       write_q;
  logic [DRAM_ADDR_WIDTH-1:0] stride_q;
  logic [RB_WIDTH-1:0]        rb_q;
  logic [ROWS_WIDTH-1:0]      rows_q;
  logic [ROWS_WIDTH-1:0]      row_cnt_q;
  logic [DRAM_ADDR_WIDTH-1:0] row_addr_q;
  logic [DRAM_ADDR_WIDTH-1:0] addr_q;
  logic [DRAM_ADDR_WIDTH-1:0] row_addr_d;
  logic [DRAM_ID_WIDTH-1:0]   id_q;
  logic [SUB_WIDTH-1:0]       sub_q;
  logic                       first_q;
  logic                       init_done_q;

  logic [SUB_WIDTH-1:0]  nreq;
  logic [BEAT_BYTES-1:0] last_mask;
  logic                  issuing;
  logic                  beat_acc;
  logic                  last_beat;
  logic                  last_row;

  assign txn_in = '{
    write:      txn_write,
    base_addr:  txn_base_addr,
    row_stride: txn_row_stride,
    row_bytes:  txn_row_bytes,
    rows:       txn_rows,
    id:         txn_id
  };

  scpad_beat_mask_gen u_mask (
    .row_bytes_i (rb_q),
    .num_req_o   (nreq),
    .last_mask_o (last_mask)
  );

  assign issuing    = (state_q == ISSUE);
  assign beat_acc   = issuing && !dram_queue_full && !be_stall;
  assign last_beat  = (sub_q == nreq);
  assign last_row   = (row_cnt_q == rows_q - 6'd1);
  assign row_addr_d = row_addr_q + stride_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      stride_q    <= '0;
      rb_q        <= '0;
      rows_q      <= '0;
      row_cnt_q   <= '0;
      row_addr_q  <= '0;
      addr_q      <= '0;
      id_q        <= '0;
      sub_q       <= '0;
      first_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (txn_valid) begin
            write_q    <= txn_in.write;
            stride_q   <= txn_in.row_stride;
            rb_q       <= txn_in.row_bytes;
            rows_q     <= txn_in.rows;
            row_cnt_q  <= '0;
            row_addr_q <= txn_in.base_addr;
            addr_q     <= txn_in.base_addr;
            id_q       <= txn_in.id;
            sub_q      <= '0;
            first_q    <= 1'b1;
            if (txn_in.rows == '0 || txn_in.row_bytes == '0)
              state_q <= FIN;
            else
              state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (beat_acc) begin
            first_q     <= 1'b0;
            init_done_q <= first_q;
            if (!last_beat) begin
              sub_q  <= sub_q + 3'd1;
              addr_q <= addr_q + DRAM_ADDR_WIDTH'(BEAT_BYTES);
            end else begin
              sub_q      <= '0;
              row_cnt_q  <= row_cnt_q + 6'd1;
              row_addr_q <= row_addr_d;
              addr_q     <= row_addr_d;
              id_q       <= id_q + 5'd1;
              if (last_row)
                state_q <= FIN;
            end
          end
        end
        FIN: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txn_ready            = (state_q == IDLE);
  assign txn_done             = (state_q == FIN);
  assign sched_valid          = issuing;
  assign sched_write          = write_q;
  assign dram_addr            = addr_q;
  assign id                   = id_q;
  assign sub_id               = sub_q;
  assign initial_request_done = init_done_q;
  assign num_request          = issuing ? nreq : '0;
  assign dram_vector_mask     =
    !issuing  ? '0 :
    last_beat ? last_mask : {BEAT_BYTES{1'b1}};

endmodule

// File: tb/tb_scpad_dram_req_gen.sv
// Randomized self-checking bench for the DRAM request
// generator against a queue-based beat model.
module tb_scpad_dram_req_gen;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        txn_valid;
  logic        txn_ready;
  logic        txn_write;
  logic [31:0] txn_base_addr;
  logic [31:0] txn_row_stride;
  logic [6:0]  txn_row_bytes;
  logic [5:0]  txn_rows;
  logic [4:0]  txn_id;
  logic        dram_queue_full;
  logic        be_stall;
  logic        sched_valid;
  logic        sched_write;
  logic [31:0] dram_addr;
  logic [4:0]  id;
  logic [2:0]  sub_id;
  logic [2:0]  num_request;
  logic [7:0]  dram_vector_mask;
  logic        initial_request_done;
  logic        txn_done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  id;
    logic [2:0]  sub;
    logic [2:0]  nreq;
    logic [7:0]  mask;
  } beat_t;

  beat_t exp_q[$];

  scpad_dram_req_gen dut (
    .CLK                  (CLK),
    .nRST                 (nRST),
    .txn_valid            (txn_valid),
    .txn_ready            (txn_ready),
    .txn_write            (txn_write),
    .txn_base_addr        (txn_base_addr),
    .txn_row_stride       (txn_row_stride),
    .txn_row_bytes        (txn_row_bytes),
    .txn_rows             (txn_rows),
    .txn_id               (txn_id),
    .dram_queue_full      (dram_queue_full),
    .be_stall             (be_stall),
    .sched_valid          (sched_valid),
    .sched_write          (sched_write),
    .dram_addr            (dram_addr),
    .id                   (id),
    .sub_id               (sub_id),
    .num_request          (num_request),
    .dram_vector_mask     (dram_vector_mask),
    .initial_request_done (initial_request_done),
    .txn_done             (txn_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic build(input logic [31:0] base,
                       input logic [31:0] stride,
                       input int rb, input int rows,
                       input int tid);
    int beats;
    beat_t b;
    exp_q.delete();
    beats = (rb + 7) / 8;
    if (rb == 0) rows = 0;
    for (int r = 0; r < rows; r++) begin
      for (int s = 0; s < beats; s++) begin
        b.addr = base + stride * 32'(r) + 32'(s * 8);
        b.id   = 5'((tid + r) % 32);
        b.sub  = 3'(s);
        b.nreq = 3'(beats - 1);
        if (s == beats - 1 && (rb % 8) != 0)
          b.mask = 8'((1 << (rb % 8)) - 1);
        else
          b.mask = 8'hFF;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic check_beat(input beat_t b,
                            input bit w);
    chk("valid", sched_valid, 1);
    chk("addr", dram_addr, b.addr);
    chk("id", id, b.id);
    chk("sub_id", sub_id, b.sub);
    chk("num_req", num_request, b.nreq);
    chk("mask", dram_vector_mask, b.mask);
    chk("write", sched_write, w);
  endtask

  task automatic check_idle_reset();
    chk("rst_valid", sched_valid, 0);
    chk("rst_ready", txn_ready, 1);
    chk("rst_addr", dram_addr, 0);
    chk("rst_id", id, 0);
    chk("rst_sub", sub_id, 0);
    chk("rst_nreq", num_request, 0);
    chk("rst_mask", dram_vector_mask, 0);
    chk("rst_write", sched_write, 0);
    chk("rst_init", initial_request_done, 0);
    chk("rst_done", txn_done, 0);
  endtask

  task automatic start_txn(input bit w,
                           input logic [31:0] base,
                           input logic [31:0] stride,
                           input int rb, input int rows,
                           input int tid);
    chk("ready_pre", txn_ready, 1);
    txn_valid      = 1'b1;
    txn_write      = w;
    txn_base_addr  = base;
    txn_row_stride = stride;
    txn_row_bytes  = 7'(rb);
    txn_rows       = 6'(rows);
    txn_id         = 5'(tid);
    @(posedge CLK);
    @(negedge CLK);
    txn_valid      = 1'b0;
    txn_write      = 1'($urandom);
    txn_base_addr  = $urandom;
    txn_row_stride = $urandom;
    txn_row_bytes  = 7'($urandom);
    txn_rows       = 6'($urandom);
    txn_id         = 5'($urandom);
  endtask

  // mode 0: no stalls, 1: random, 2: scripted on beat 2
  task automatic run_txn(input bit w,
                         input logic [31:0] base,
                         input logic [31:0] stride,
                         input int rb, input int rows,
                         input int tid, input int mode);
    int n, idx, cyc, hold;
    bit prev_first, prev_last, done, acc;
    build(base, stride, rb, rows, tid);
    n = exp_q.size();
    start_txn(w, base, stride, rb, rows, tid);
    idx = 0; cyc = 0; hold = 0; done = 0;
    prev_first = 0;
    prev_last = (n == 0);
    while (!done && cyc < 2000) begin
      dram_queue_full = 1'b0;
      be_stall = 1'b0;
      if (mode == 1) begin
        dram_queue_full = ($urandom_range(99) < 25);
        be_stall = ($urandom_range(99) < 15);
      end else if (mode == 2 && idx == 2) begin
        if (hold < 3) dram_queue_full = 1'b1;
        else if (hold == 3) be_stall = 1'b1;
        hold++;
      end
      #1;
      chk("init_done", initial_request_done, prev_first);
      chk("txn_done", txn_done, prev_last);
      chk("ready_busy", txn_ready, 0);
      acc = 0;
      if (idx < n) begin
        check_beat(exp_q[idx], w);
        acc = !dram_queue_full && !be_stall;
      end else begin
        chk("valid_extra", sched_valid, 0);
      end
      prev_first = acc && (idx == 0);
      prev_last = acc && (idx == n - 1);
      if (txn_done) done = 1;
      if (acc) idx++;
      @(negedge CLK);
      cyc++;
    end
    chk("txn_finished", done, 1);
    chk("beat_count", idx, n);
    dram_queue_full = 1'b0;
    be_stall = 1'b0;
    #1;
    chk("ready_after", txn_ready, 1);
    chk("done_once", txn_done, 0);
    chk("valid_after", sched_valid, 0);
    @(negedge CLK);
  endtask

  task automatic reset_mid_txn();
    int idx;
    build(32'h3000, 32'h0, 64, 1, 7);
    start_txn(1'b0, 32'h3000, 32'h0, 64, 1, 7);
    idx = 0;
    while (idx < 4) begin
      #1;
      check_beat(exp_q[idx], 1'b0);
      idx++;
      @(negedge CLK);
    end
    #1;
    check_beat(exp_q[4], 1'b0);
    nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    check_idle_reset();
    nRST = 1'b1;
    @(negedge CLK);
    #1;
    chk("post_rst_done", txn_done, 0);
    chk("post_rst_valid", sched_valid, 0);
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0;
    txn_valid = 1'b0;
    txn_write = 1'b0;
    txn_base_addr = '0;
    txn_row_stride = '0;
    txn_row_bytes = '0;
    txn_rows = '0;
    txn_id = '0;
    dram_queue_full = 1'b0;
    be_stall = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    check_idle_reset();
    nRST = 1'b1;
    @(negedge CLK);

    run_txn(1'b1, 32'h1000, 32'h0, 64, 1, 3, 0);
    run_txn(1'b0, 32'h1800, 32'h40, 20, 1, 9, 0);
    run_txn(1'b0, 32'h2000, 32'h100, 16, 2, 31, 0);
    run_txn(1'b1, 32'h4000, 32'h0, 40, 1, 2, 2);
    run_txn(1'b0, 32'h5000, 32'h80, 24, 0, 5, 0);
    run_txn(1'b1, 32'h6000, 32'h80, 0, 3, 5, 0);
    run_txn(1'b0, 32'h7000, 32'h0, 5, 1, 1, 0);
    run_txn(1'b0, 32'hFFFF_FFF0, 32'h0, 32, 1, 4, 0);
    reset_mid_txn();
    run_txn(1'b1, 32'h8000, 32'h40, 64, 1, 12, 0);

    for (int t = 0; t < 30; t++) begin
      int rb;
      rb = ($urandom_range(9) == 0) ? 0
         : int'($urandom_range(64, 1));
      run_txn(1'($urandom), $urandom,
              32'($urandom_range(4096)), rb,
              int'($urandom_range(4)),
              int'($urandom_range(31)), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
